// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instructions into the IR and steps decoder-driven execute sub-states.
module instr_sequencer #(
  parameter int          MAX_EXEC_CYCLES = 4,
  parameter logic [30:0] FETCH_CW        = 31'h20000008
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic        stall,
  input  logic [30:0] dec_controlword,
  input  logic [1:0]  dec_nextState,
  input  logic [63:0] dec_K,
  output logic [31:0] instruction,
  output logic [1:0]  state,
  output logic [30:0] controlword,
  output logic [63:0] K,
  output logic        fetching,
  output logic [31:0] retired,
  output logic        exec_error
);
  typedef enum logic {FETCH, EXEC} phase_t;
  localparam logic [30:0] IDLE_CW    = 31'h00000008;
  localparam logic [30:0] STALL_MASK = 31'h1FFFFE7F;
  localparam logic [3:0]  LAST_CNT   = 4'(MAX_EXEC_CYCLES - 1);
  phase_t      phase;
  logic [3:0]  exec_cnt;
  logic [30:0] raw_cw;
  // Reset overrides the registered phase so the reset cycle already looks like FETCH.
  assign fetching    = reset || phase == FETCH;
  assign raw_cw      = fetching ? (mem_ready ? FETCH_CW : IDLE_CW) : dec_controlword;
  assign controlword = stall ? raw_cw & STALL_MASK : raw_cw;
  assign K           = fetching ? '0 : dec_K;
  always_ff @(posedge clock) begin
    if (reset) begin
      phase       <= FETCH;
      instruction <= '0;
      state       <= '0;
      exec_cnt    <= '0;
      retired     <= '0;
      exec_error  <= 1'b0;
    end else if (!stall) begin
      if (phase == FETCH) begin
        if (mem_ready) begin
          instruction <= mem_data;
          state       <= '0;
          exec_cnt    <= '0;
          phase       <= EXEC;
        end
      end else if (dec_nextState == 2'b00) begin
        retired <= retired + 32'd1;
        state   <= '0;
        phase   <= FETCH;
      end else if (exec_cnt == LAST_CNT) begin
        state      <= '0;
        exec_error <= 1'b1;
        phase      <= FETCH;
      end else begin
        state    <= dec_nextState;
        exec_cnt <= exec_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized scoreboard bench with an instruction-level reference model.
module tb_instr_sequencer;
  localparam int          MAX  = 4;
  localparam logic [30:0] FCW  = 31'h20000008;
  localparam logic [30:0] IDLE = 31'h00000008;
  localparam logic [30:0] M    = 31'h1FFFFE7F;
  logic clock = 1'b0;
  logic reset, mem_ready, stall;
  logic [31:0] mem_data, instruction, retired;
  logic [30:0] dec_controlword, controlword;
  logic [1:0]  dec_nextState, state;
  logic [63:0] dec_K, K;
  logic        fetching, exec_error;

  instr_sequencer #(.MAX_EXEC_CYCLES(MAX), .FETCH_CW(FCW)) dut (
    .clock(clock), .reset(reset), .mem_data(mem_data), .mem_ready(mem_ready),
    .stall(stall), .dec_controlword(dec_controlword), .dec_nextState(dec_nextState),
    .dec_K(dec_K), .instruction(instruction), .state(state), .controlword(controlword),
    .K(K), .fetching(fetching), .retired(retired), .exec_error(exec_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        regs;
    logic        fetching;
    logic [1:0]  state;
    logic [31:0] ir;
    logic [30:0] cw;
    logic [63:0] k;
    logic [31:0] ret;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_ir   = '0;
  logic [31:0] m_ret  = '0;
  logic        m_err  = 1'b0;
  logic [1:0]  plan[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clock);
    #2;
    if (q.size() != 0) begin
      cur = q.pop_front();
      chk("fetching", 64'(fetching), 64'(cur.fetching));
      chk("controlword", 64'(controlword), 64'(cur.cw));
      chk("K", K, cur.k);
      if (cur.regs) begin
        chk("state", 64'(state), 64'(cur.state));
        chk("instruction", 64'(instruction), 64'(cur.ir));
        chk("retired", 64'(retired), 64'(cur.ret));
        chk("exec_error", 64'(exec_error), 64'(cur.err));
      end
    end
  end

  task automatic drive(input logic rst, rdy, stl, input logic [31:0] md, input logic [30:0] dcw,
                       input logic [1:0] dns, input logic [63:0] dk, input exp_t e);
    @(negedge clock);
    reset = rst; mem_ready = rdy; stall = stl; mem_data = md;
    dec_controlword = dcw; dec_nextState = dns; dec_K = dk;
    q.push_back(e);
  endtask

  function automatic exp_t fetch_exp(input logic rdy, stl);
    exp_t e;
    e.regs = 1'b1; e.fetching = 1'b1; e.state = 2'b00; e.ir = m_ir;
    e.cw = (rdy ? FCW : IDLE) & (stl ? M : '1);
    e.k = '0; e.ret = m_ret; e.err = m_err;
    return e;
  endfunction

  // One instruction: fetch wait, load, then walk the planned nextState list (abort_at>=0 resets there).
  task automatic run_instr(input logic [31:0] w, input int pct, input int forced, input logic fixed,
                           input logic [30:0] fcw, input logic [63:0] fk, input int abort_at);
    int n, lim, k, s;
    logic stl;
    logic [30:0] dcw;
    logic [63:0] dk;
    exp_t e;
    n = plan.size(); lim = (n > MAX) ? MAX : n; k = 0; s = 0;
    repeat ($urandom_range(0, 2)) begin
      stl = $urandom_range(0, 99) < pct;
      drive(0, 0, stl, $urandom, 31'($urandom), 2'($urandom), {$urandom, $urandom}, fetch_exp(0, stl));
    end
    do begin
      stl = $urandom_range(0, 99) < pct;
      drive(0, 1, stl, w, 31'($urandom), 2'($urandom), {$urandom, $urandom}, fetch_exp(1, stl));
    end while (stl);
    m_ir = w;
    while (k < lim) begin
      if (k == abort_at) begin
        e = fetch_exp(0, 0);
        e.regs = 1'b0;
        drive(1, 0, 0, $urandom, 31'($urandom), 2'($urandom), {$urandom, $urandom}, e);
        m_ir = '0; m_ret = '0; m_err = 1'b0;
        return;
      end
      stl = (s < forced) || ($urandom_range(0, 99) < pct);
      dcw = fixed ? fcw : 31'($urandom);
      dk  = fixed ? fk : {$urandom, $urandom};
      e.regs = 1'b1; e.fetching = 1'b0; e.state = (k == 0) ? 2'b00 : plan[k-1];
      e.ir = m_ir; e.cw = dcw & (stl ? M : '1); e.k = dk; e.ret = m_ret; e.err = m_err;
      drive(0, 1'($urandom), stl, $urandom, dcw, stl ? 2'($urandom) : plan[k], dk, e);
      if (stl) s++;
      else k++;
    end
    if (n > MAX) m_err = 1'b1;
    else m_ret = m_ret + 32'd1;
  endtask

  initial begin
    int n;
    exp_t e;
    reset = 1; mem_ready = 0; stall = 0; mem_data = '0;
    dec_controlword = '0; dec_nextState = '0; dec_K = '0;
    e = fetch_exp(0, 0);
    e.regs = 1'b0;
    drive(1, 0, 0, '0, 31'h7FFFFFFF, 2'b11, '1, e);
    drive(1, 0, 0, '0, 31'h7FFFFFFF, 2'b11, '1, fetch_exp(0, 0));
    plan = {2'b00};
    run_instr(32'h91001441, 0, 0, 1, 31'h01100000, 64'd5, -1);
    plan = {2'b01, 2'b10, 2'b00};
    run_instr($urandom, 0, 0, 0, '0, '0, -1);
    plan = {2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    run_instr($urandom, 0, 0, 0, '0, '0, -1);
    plan = {2'b00};
    run_instr($urandom, 0, 0, 0, '0, '0, -1);
    plan = {2'b01, 2'b00};
    run_instr($urandom, 0, 3, 1, 31'h7FFFFFFF, 64'h0123456789ABCDEF, -1);
    repeat (80) begin
      plan.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n - 1; i++) plan.push_back(2'($urandom_range(1, 3)));
      plan.push_back(2'b00);
      run_instr($urandom, 25, 0, 0, '0, '0, -1);
    end
    plan = {2'b01, 2'b10, 2'b00};
    run_instr($urandom, 0, 0, 0, '0, '0, 2);
    plan = {2'b00};
    run_instr($urandom, 0, 0, 0, '0, '0, -1);
    drive(0, 0, 0, '0, '0, '0, '0, fetch_exp(0, 0));
    @(negedge clock);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-register and state sequencer sitting directly upstream of the per-format decoders (I-arithmetic, R-type, D-type, branch).
- Fetches a 32-bit instruction from memory under a ready handshake and latches it into the IR.
- Drives the decoders with `instruction` and `state`, then consumes their `controlword`, `nextState` and `K`.
- Emits the final control word and K to the datapath, stepping multi-cycle instructions until a decoder returns nextState 2'b00.

Parameters:
- MAX_EXEC_CYCLES, 4: execute-cycle limit per instruction before the watchdog aborts it (range 1..15).
- FETCH_CW, 31'h20000008: control word driven on the fetch-complete cycle (Psel=01 increments PC, EN_PC=1).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_data  in  32  instruction word from memory data bus.
- mem_ready  in  1  memory has valid data on mem_data this cycle.
- stall  in  1  freeze sequencer and suppress datapath writes.
- dec_controlword  in  31  control word from selected decoder.
- dec_nextState  in  2  next exec state from selected decoder.
- dec_K  in  64  constant from selected decoder.
- instruction  out  32  IR contents, fed to decoders.
- state  out  2  current exec sub-state, fed to decoders.
- controlword  out  31  control word to datapath.
- K  out  64  constant to datapath.
- fetching  out  1  high while in FETCH phase.
- retired  out  32  count of completed instructions, wraps.
- exec_error  out  1  sticky watchdog-abort flag.

Behaviour:
Control word bit map:
- [30:29] Psel, [28:24] DA, [23:19] SA, [18:14] SB, [13:9] Fsel.
- [8] regW, [7] ramW, [6] EN_MEM, [5] EN_ALU, [4] EN_B, [3] EN_PC, [2] Bsel, [1] PCsel, [0] SL.

Reset (synchronous, wins over every other input):
- phase=FETCH, instruction=0, state=2'b00, exec_cnt=0, retired=0, exec_error=0.
- Outputs in the reset cycle follow the FETCH rules below.

FETCH:
- fetching=1, K=0.
- While mem_ready=0: controlword=31'h00000008 (EN_PC only).
- While mem_ready=1: controlword=FETCH_CW. At the clock edge: IR<=mem_data, state<=00, exec_cnt<=0, phase<=EXEC.
- Latency is one cycle from mem_ready high to the first EXEC cycle.

EXEC:
- fetching=0, controlword=dec_controlword, K=dec_K (combinational passthrough).
- If dec_nextState==00 at the edge: retired<=retired+1 (wraps 2^32-1 -> 0), phase<=FETCH, state<=00.
- Otherwise: state<=dec_nextState, exec_cnt<=exec_cnt+1.
- Watchdog: if exec_cnt==MAX_EXEC_CYCLES-1 and dec_nextState!=00 at the edge, then phase<=FETCH, state<=00, exec_error<=1, retired unchanged.

stall=1 (any phase):
- IR, state, phase, exec_cnt, retired and exec_error all hold.
- controlword is the phase value with Psel, regW and ramW forced to 0.
- K passes through unchanged.
- In FETCH, mem_ready is ignored while stalled: no IR load.

Other boundary rules:
- stall and mem_ready high in the same cycle: stall wins.
- exec_error clears only on reset.
- Reset mid-EXEC: the instruction is abandoned and retired does not increment.

Test Plan:
- Reset with mem_ready=0 -> fetching=1, controlword=31'h00000008, retired=0, exec_error=0, K=0.
- ADDI fetch: mem_data=32'h91001441 with mem_ready=1 for one cycle -> next cycle instruction=32'h91001441, state=00, controlword=dec_controlword. Decoder gives K=64'd5, DA=1, SA=2, nextState=00. Following cycle fetching=1 and retired=1.
- Multi-cycle instruction: decoder returns nextState sequence 01, 10, 00 -> state outputs 00, 01, 10 over three EXEC cycles, then FETCH, retired increments by 1, exec_error=0.
- Watchdog: decoder always returns nextState=01 with MAX_EXEC_CYCLES=4 -> exactly 4 EXEC cycles, then FETCH, exec_error=1, retired unchanged; exec_error stays 1 through the next good instruction.
- Stall in EXEC for 3 cycles with dec_controlword=31'h7FFFFFFF -> controlword=31'h1FFFFE7F, state/IR/retired held; resumes normally when stall drops.
- Reset asserted mid-EXEC with retired preset to 32'hFFFFFFFF -> next cycle FETCH, retired=0, IR=0. Separately, with no reset, retire at 32'hFFFFFFFF -> retired wraps to 0.
